// File: rtl/key_seq_pkg.sv
// rtl/key_seq_pkg.sv - shared state codes, PIO addresses and event type for the key event sequencer
package key_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT_MASK = 3'd0;
    localparam state_t ST_IDLE      = 3'd1;
    localparam state_t ST_RD_CAP    = 3'd2;
    localparam state_t ST_CAP_WAIT  = 3'd3;
    localparam state_t ST_CLR       = 3'd4;
    localparam state_t ST_RD_DATA   = 3'd5;
    localparam state_t ST_DATA_WAIT = 3'd6;
    localparam state_t ST_EMIT      = 3'd7;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    typedef struct packed {
        logic [4:0] code;
        logic       level;
    } key_evt_t;

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - synchronous event FIFO with full/empty flags
module key_event_fifo
    import key_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  key_evt_t push_data,
    input  logic     pop,
    output key_evt_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    key_evt_t       mem [DEPTH];
    logic [AW:0]    wptr;
    logic [AW:0]    rptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a push needs when full.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/key_event_sequencer.sv
// rtl/key_event_sequencer.sv - Avalon-MM master servicing the key PIO and queueing one event per captured edge
module key_event_sequencer
    import key_seq_pkg::*;
#(
    parameter int               NKEYS      = 20,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [NKEYS-1:0] MASK_INIT  = 20'hFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       av_address,
    output logic             av_chipselect,
    output logic             av_write_n,
    output logic [31:0]      av_writedata,
    input  logic [31:0]      av_readdata,
    input  logic             key_irq,
    input  logic             cfg_load,
    input  logic [NKEYS-1:0] cfg_mask,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [4:0]       evt_code,
    output logic             evt_level,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [NKEYS-1:0] mask_reg;
    logic [NKEYS-1:0] cap_reg;
    logic [NKEYS-1:0] cap_rd;
    logic [NKEYS-1:0] cap_nxt;
    logic [31:0]      lvl_reg;
    logic             cfg_pending;
    logic [4:0]       low_idx;
    logic             fifo_full;
    logic             fifo_empty;
    logic             can_push;
    logic             push;
    key_evt_t         push_evt;
    key_evt_t         head_evt;

    assign cap_rd  = av_readdata[NKEYS-1:0] & mask_reg;
    assign cap_nxt = cap_reg & (cap_reg - 1'b1);

    always_comb begin
        low_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (cap_reg[i]) low_idx = 5'(i);
        end
    end

    assign can_push = ~fifo_full | (evt_valid & evt_ready);
    assign push     = (state == ST_EMIT) && (cap_reg != '0) && can_push;
    assign push_evt = '{code: low_idx, level: lvl_reg[low_idx]};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT_MASK: state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (cfg_pending)  state_nxt = ST_INIT_MASK;
                else if (key_irq) state_nxt = ST_RD_CAP;
            end
            ST_RD_CAP:    state_nxt = ST_CAP_WAIT;
            ST_CAP_WAIT:  state_nxt = (cap_rd == '0) ? ST_IDLE : ST_CLR;
            ST_CLR:       state_nxt = ST_RD_DATA;
            ST_RD_DATA:   state_nxt = ST_DATA_WAIT;
            ST_DATA_WAIT: state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (cap_reg == '0 || (push && cap_nxt == '0)) state_nxt = ST_IDLE;
            end
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_INIT_MASK;
            mask_reg    <= MASK_INIT;
            cfg_pending <= 1'b0;
            cap_reg     <= '0;
            lvl_reg     <= '0;
        end else begin
            state <= state_nxt;
            // A load coinciding with the mask write keeps the request alive so the new mask still goes out.
            if (cfg_load) begin
                mask_reg    <= cfg_mask;
                cfg_pending <= 1'b1;
            end else if (state == ST_INIT_MASK) begin
                cfg_pending <= 1'b0;
            end
            if (state == ST_CAP_WAIT) cap_reg <= cap_rd;
            else if (push)            cap_reg <= cap_nxt;
            if (state == ST_DATA_WAIT) lvl_reg <= av_readdata;
        end
    end

    // Bus is decoded from state; held idle while reset is asserted so the PIO never sees a stray write.
    always_comb begin
        av_address    = ADDR_DATA;
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        av_writedata  = '0;
        if (!reset) begin
            case (state)
                ST_INIT_MASK: begin
                    av_address               = ADDR_MASK;
                    av_chipselect            = 1'b1;
                    av_write_n               = 1'b0;
                    av_writedata[NKEYS-1:0]  = mask_reg;
                end
                ST_RD_CAP: av_address = ADDR_CAP;
                ST_CLR: begin
                    av_address               = ADDR_CAP;
                    av_chipselect            = 1'b1;
                    av_write_n               = 1'b0;
                    av_writedata[NKEYS-1:0]  = cap_reg;
                end
                default: ;
            endcase
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (evt_ready),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_level = head_evt.level;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_key_event_sequencer.sv
// tb/tb_key_event_sequencer.sv - scoreboard bench with a behavioural key PIO for the key event sequencer
module tb_key_event_sequencer;
    import key_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        key_irq;
    logic        cfg_load = 1'b0;
    logic [19:0] cfg_mask = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [4:0]  evt_code;
    logic        evt_level;
    logic        busy;

    logic [19:0] keys = '0;
    logic [19:0] keys_d;
    logic [19:0] pio_mask;
    logic [19:0] pio_cap;

    int          total = 0;
    int          bad = 0;
    logic [33:0] exp_wr[$];
    logic [5:0]  exp_evt[$];
    logic [33:0] wr_e;
    logic [5:0]  ev_e;

    always #5 clk = ~clk;

    key_event_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .key_irq       (key_irq),
        .cfg_load      (cfg_load),
        .cfg_mask      (cfg_mask),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_level     (evt_level),
        .busy          (busy)
    );

    // Key PIO: registered readdata, rising-edge capture, write-one-to-clear capture register.
    always @(posedge clk) begin
        if (reset) begin
            keys_d      <= '0;
            pio_mask    <= '0;
            pio_cap     <= '0;
            av_readdata <= '0;
        end else begin
            keys_d <= keys;
            if (av_chipselect && !av_write_n && av_address == ADDR_MASK)
                pio_mask <= av_writedata[19:0];
            pio_cap <= (pio_cap & ~((av_chipselect && !av_write_n && av_address == ADDR_CAP)
                                    ? av_writedata[19:0] : 20'h0)) | (keys & ~keys_d);
            case (av_address)
                ADDR_DATA: av_readdata <= {12'h0, keys};
                ADDR_MASK: av_readdata <= {12'h0, pio_mask};
                ADDR_CAP:  av_readdata <= {12'h0, pio_cap};
                default:   av_readdata <= '0;
            endcase
        end
    end
    assign key_irq = |(pio_cap & pio_mask);

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || key_irq || evt_valid) && n < 300) begin
            tick();
            n++;
        end
        chk(name, 40'(n < 300), 40'd1);
    endtask

    always @(negedge clk) begin
        if (!reset && av_chipselect && !av_write_n) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %08h want none", av_address, av_writedata);
            end else begin
                wr_e = exp_wr.pop_front();
                chk("bus_write", {6'h0, av_address, av_writedata}, {6'h0, wr_e});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_evt.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got code %0d level %0d want none", evt_code, evt_level);
            end else begin
                ev_e = exp_evt.pop_front();
                chk("event", {34'h0, evt_code, evt_level}, {34'h0, ev_e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 40'(busy), 40'd1);
        chk("rst_evt_valid", 40'(evt_valid), 40'd0);
        chk("rst_evt_code", 40'(evt_code), 40'd0);
        chk("rst_evt_level", 40'(evt_level), 40'd0);
        chk("rst_address", 40'(av_address), 40'd0);
        chk("rst_chipselect", 40'(av_chipselect), 40'd0);
        chk("rst_write_n", 40'(av_write_n), 40'd1);

        // Reset release: one mask write, then idle.
        exp_wr.push_back({ADDR_MASK, 32'h000F_FFFF});
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("init_busy_c0", 40'(busy), 40'd1);
        tick();
        @(negedge clk);
        chk("init_busy_c1", 40'(busy), 40'd0);
        repeat (5) tick();
        chk("idle_busy", 40'(busy), 40'd0);

        // Single key 5 edge, latency check.
        exp_wr.push_back({ADDR_CAP, 32'h0000_0020});
        exp_evt.push_back({5'd5, 1'b1});
        keys[5] = 1'b1;
        tick();
        @(negedge clk);
        chk("k5_irq_c0", 40'(key_irq), 40'd1);
        repeat (4) tick();
        @(negedge clk);
        chk("k5_irq_c4", 40'(key_irq), 40'd0);
        repeat (2) tick();
        @(negedge clk);
        chk("k5_valid_c6", 40'(evt_valid), 40'd0);
        tick();
        @(negedge clk);
        chk("k5_valid_c7", 40'(evt_valid), 40'd1);
        chk("k5_code_c7", 40'(evt_code), 40'd5);
        chk("k5_level_c7", 40'(evt_level), 40'd1);
        keys = '0;
        wait_idle("k5_drain");

        // Keys 0, 3, 19 together: lowest index first on consecutive cycles.
        exp_wr.push_back({ADDR_CAP, 32'h0008_0009});
        exp_evt.push_back({5'd0, 1'b1});
        exp_evt.push_back({5'd3, 1'b1});
        exp_evt.push_back({5'd19, 1'b1});
        keys = 20'h80009;
        tick();
        repeat (7) tick();
        @(negedge clk);
        chk("multi_code_c7", 40'(evt_code), 40'd0);
        tick();
        @(negedge clk);
        chk("multi_code_c8", 40'(evt_code), 40'd3);
        tick();
        @(negedge clk);
        chk("multi_code_c9", 40'(evt_code), 40'd19);
        keys = '0;
        wait_idle("multi_drain");

        // Ten keys with consumer stalled: FIFO fills, FSM waits in EMIT, then drains in order.
        evt_ready = 1'b0;
        exp_wr.push_back({ADDR_CAP, 32'h0000_03FF});
        for (int k = 0; k < 10; k++) exp_evt.push_back({5'(k), 1'b1});
        keys = 20'h003FF;
        repeat (25) tick();
        @(negedge clk);
        chk("stall_busy", 40'(busy), 40'd1);
        chk("stall_valid", 40'(evt_valid), 40'd1);
        chk("stall_head_code", 40'(evt_code), 40'd0);
        keys = '0;
        evt_ready = 1'b1;
        tick();
        wait_idle("stall_drain");

        // Key 4 pulse (low at data read), key 7 edge arriving during the clear write.
        exp_wr.push_back({ADDR_CAP, 32'h0000_0010});
        exp_evt.push_back({5'd4, 1'b0});
        exp_wr.push_back({ADDR_CAP, 32'h0000_0080});
        exp_evt.push_back({5'd7, 1'b1});
        keys[4] = 1'b1;
        tick();
        keys[4] = 1'b0;
        tick();
        tick();
        tick();
        keys[7] = 1'b1;
        wait_idle("late_edge_drain");
        keys = '0;

        // Mask reload during a pass is deferred until IDLE; masked key then stays silent.
        exp_wr.push_back({ADDR_CAP, 32'h0000_0002});
        exp_evt.push_back({5'd1, 1'b1});
        exp_wr.push_back({ADDR_MASK, 32'h0000_0001});
        keys = 20'h00002;
        tick();
        tick();
        tick();
        cfg_mask = 20'h00001;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("cfg_no_write_c7", 40'(av_chipselect), 40'd0);
        tick();
        @(negedge clk);
        chk("cfg_write_c8", 40'(av_chipselect), 40'd1);
        chk("cfg_addr_c8", 40'(av_address), 40'(ADDR_MASK));
        keys = 20'h00006;
        repeat (10) tick();
        @(negedge clk);
        chk("masked_irq", 40'(key_irq), 40'd0);
        chk("masked_busy", 40'(busy), 40'd0);
        chk("masked_valid", 40'(evt_valid), 40'd0);

        repeat (5) tick();
        chk("wr_queue_empty", 40'(exp_wr.size()), 40'd0);
        chk("evt_queue_empty", 40'(exp_evt.size()), 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
